// File: rtl/fighter_collision_engine.sv
// fighter_collision_engine: frame-synchronous two-player hitbox/hurtbox resolver with saturating scores
module fighter_collision_engine #(
    parameter int COORD_W     = 10,
    parameter int SPRITE_W    = 64,
    parameter int SPRITE_H    = 128,
    parameter int HURT_MARGIN = 10,
    parameter int HIT_W       = 30,
    parameter int HIT_H       = 60,
    parameter int RECOV_EXT   = 12,
    parameter int CNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               round_clear,
    input  logic [2:0]         p1_state,
    input  logic [COORD_W-1:0] p1_x,
    input  logic [COORD_W-1:0] p1_y,
    input  logic               p1_face,
    input  logic [2:0]         p2_state,
    input  logic [COORD_W-1:0] p2_x,
    input  logic [COORD_W-1:0] p2_y,
    input  logic               p2_face,
    output logic               busy,
    output logic               hit_on_p1,
    output logic               hit_on_p2,
    output logic               trade,
    output logic [CNT_W-1:0]   p1_score,
    output logic [CNT_W-1:0]   p2_score
);
    localparam int W2 = COORD_W + 2;
    localparam logic signed [W2-1:0] MAXV = W2'((1 << COORD_W) - 1);
    localparam logic signed [W2-1:0] HM   = W2'(HURT_MARGIN);
    localparam logic signed [W2-1:0] HRX  = W2'(SPRITE_W - HURT_MARGIN);
    localparam logic signed [W2-1:0] SW   = W2'(SPRITE_W);
    localparam logic signed [W2-1:0] SH   = W2'(SPRITE_H);
    localparam logic signed [W2-1:0] HW   = W2'(HIT_W);
    localparam logic signed [W2-1:0] HY1  = W2'((SPRITE_H - HIT_H) / 2);
    localparam logic signed [W2-1:0] HY2  = W2'((SPRITE_H - HIT_H) / 2 + HIT_H);
    localparam logic signed [W2-1:0] RX   = W2'(RECOV_EXT);

    typedef enum logic [1:0] {IDLE, SNAP, BOX, CMP} state_t;
    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
    } box_t;

    state_t st, st_nx;
    logic [2:0]         s1_st, s2_st;
    logic [COORD_W-1:0] s1_x, s1_y, s2_x, s2_y;
    logic               s1_f, s2_f;
    box_t               hit1, hit2, hurt1, hurt2;
    logic               hv1, hv2, done1, done2;
    logic               h1, h2;

    function automatic logic [COORD_W-1:0] clampc(input logic signed [W2-1:0] v);
        return v < 0 ? '0 : (v > MAXV ? MAXV[COORD_W-1:0] : v[COORD_W-1:0]);
    endfunction

    // Recovery stretches the hurtbox toward the side the fighter is facing
    function automatic box_t hurt_box(input logic [2:0] s, input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y, input logic f);
        logic signed [W2-1:0] xs, ys;
        xs = $signed(W2'(x));
        ys = $signed(W2'(y));
        hurt_box.x1 = clampc(xs + HM - ((s == 3'd5 && !f) ? RX : '0));
        hurt_box.x2 = clampc(xs + HRX + ((s == 3'd5 && f) ? RX : '0));
        hurt_box.y1 = y;
        hurt_box.y2 = clampc(ys + SH);
    endfunction

    function automatic box_t hit_box(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                                     input logic f);
        logic signed [W2-1:0] xs, ys;
        xs = $signed(W2'(x));
        ys = $signed(W2'(y));
        hit_box.x1 = clampc(f ? xs + SW : xs - HW);
        hit_box.x2 = clampc(f ? xs + SW + HW : xs);
        hit_box.y1 = clampc(ys + HY1);
        hit_box.y2 = clampc(ys + HY2);
    endfunction

    function automatic logic ov(input box_t a, input box_t b);
        return a.x1 < b.x2 && b.x1 < a.x2 && a.y1 < b.y2 && b.y1 < a.y2;
    endfunction

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = frame_tick ? SNAP : IDLE;
            SNAP:    st_nx = BOX;
            BOX:     st_nx = CMP;
            default: st_nx = IDLE;
        endcase
    end

    assign busy = st != IDLE;
    assign h2   = hv1 && ov(hit1, hurt2) && !done1;
    assign h1   = hv2 && ov(hit2, hurt1) && !done2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            {s1_st, s1_x, s1_y, s1_f, s2_st, s2_x, s2_y, s2_f} <= '0;
            {hit1, hit2, hurt1, hurt2, hv1, hv2} <= '0;
            {done1, done2, hit_on_p1, hit_on_p2, trade} <= '0;
            p1_score <= '0;
            p2_score <= '0;
        end else begin
            st <= st_nx;
            if (st == IDLE && frame_tick) begin
                {s1_st, s1_x, s1_y, s1_f} <= {p1_state, p1_x, p1_y, p1_face};
                {s2_st, s2_x, s2_y, s2_f} <= {p2_state, p2_x, p2_y, p2_face};
                if (p1_state != 3'd4) done1 <= 1'b0;
                if (p2_state != 3'd4) done2 <= 1'b0;
            end
            if (st == SNAP) begin
                hit1  <= hit_box(s1_x, s1_y, s1_f);
                hit2  <= hit_box(s2_x, s2_y, s2_f);
                hurt1 <= hurt_box(s1_st, s1_x, s1_y, s1_f);
                hurt2 <= hurt_box(s2_st, s2_x, s2_y, s2_f);
                hv1   <= s1_st == 3'd4;
                hv2   <= s2_st == 3'd4;
            end
            hit_on_p2 <= st == BOX && h2;
            hit_on_p1 <= st == BOX && h1;
            trade     <= st == BOX && h1 && h2;
            if (st == BOX && h2) done1 <= 1'b1;
            if (st == BOX && h1) done2 <= 1'b1;
            if (st == BOX && h2 && !(&p1_score)) p1_score <= p1_score + CNT_W'(1);
            if (st == BOX && h1 && !(&p2_score)) p2_score <= p2_score + CNT_W'(1);
            // Clear beats a simultaneous report; the pulses still go out
            if (round_clear) begin
                p1_score <= '0;
                p2_score <= '0;
                done1    <= 1'b0;
                done2    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fighter_collision_engine.sv
// tb_fighter_collision_engine: directed and randomized checks against a box-geometry reference model
module tb_fighter_collision_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, round_clear = 1'b0;
    logic [2:0] p1_state = '0, p2_state = '0;
    logic [9:0] p1_x = '0, p1_y = '0, p2_x = '0, p2_y = '0;
    logic       p1_face = 1'b0, p2_face = 1'b0;
    logic       busy, hit_on_p1, hit_on_p2, trade;
    logic [3:0] p1_score, p2_score;

    int n_chk = 0, n_err = 0;
    int m_sc1 = 0, m_sc2 = 0;
    bit m_done1 = 0, m_done2 = 0;

    fighter_collision_engine dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .round_clear(round_clear),
        .p1_state(p1_state), .p1_x(p1_x), .p1_y(p1_y), .p1_face(p1_face),
        .p2_state(p2_state), .p2_x(p2_x), .p2_y(p2_y), .p2_face(p2_face),
        .busy(busy), .hit_on_p1(hit_on_p1), .hit_on_p2(hit_on_p2), .trade(trade),
        .p1_score(p1_score), .p2_score(p2_score)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic int cl(input int v);
        return v < 0 ? 0 : (v > 1023 ? 1023 : v);
    endfunction

    // Does attacker a's hitbox land on defender b's hurtbox (geometry only)
    function automatic bit lands(input int as, ax, ay, af, bs, bx, by, bf);
        int hx1, hx2, hy1, hy2, ux1, ux2, uy1, uy2;
        if (as != 4) return 0;
        hx1 = af ? cl(ax + 64) : cl(ax - 30);
        hx2 = af ? cl(ax + 94) : ax;
        hy1 = cl(ay + 34);
        hy2 = cl(ay + 94);
        ux1 = cl(bx + 10 - ((bs == 5 && bf == 0) ? 12 : 0));
        ux2 = cl(bx + 54 + ((bs == 5 && bf == 1) ? 12 : 0));
        uy1 = by;
        uy2 = cl(by + 128);
        return hx1 < ux2 && ux1 < hx2 && hy1 < uy2 && uy1 < hy2;
    endfunction

    task automatic all_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_hit1"}, hit_on_p1, 0);
        check({tag, "_hit2"}, hit_on_p2, 0);
        check({tag, "_trade"}, trade, 0);
        check({tag, "_sc1"}, p1_score, 0);
        check({tag, "_sc2"}, p2_score, 0);
    endtask

    task automatic do_tick(input string tag, input int as, ax, ay, af, bs, bx, by, bf, input bit rc);
        bit e1, e2;
        p1_state = 3'(as); p1_x = 10'(ax); p1_y = 10'(ay); p1_face = af[0];
        p2_state = 3'(bs); p2_x = 10'(bx); p2_y = 10'(by); p2_face = bf[0];
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        p1_state = 3'($urandom); p1_x = 10'($urandom); p1_y = 10'($urandom);
        p2_state = 3'($urandom); p2_x = 10'($urandom); p2_y = 10'($urandom);
        if (as != 4) m_done1 = 0;
        if (bs != 4) m_done2 = 0;
        e2 = lands(as, ax, ay, af, bs, bx, by, bf) && !m_done1;
        e1 = lands(bs, bx, by, bf, as, ax, ay, af) && !m_done2;
        if (e2) begin m_done1 = 1; if (m_sc1 < 15) m_sc1++; end
        if (e1) begin m_done2 = 1; if (m_sc2 < 15) m_sc2++; end
        if (rc) begin m_sc1 = 0; m_sc2 = 0; m_done1 = 0; m_done2 = 0; end
        check({tag, "_busy_snap"}, busy, 1);
        check({tag, "_early_hit2"}, hit_on_p2, 0);
        @(posedge clk); #1;
        check({tag, "_busy_box"}, busy, 1);
        round_clear = rc;
        @(posedge clk); #1;
        round_clear = 1'b0;
        check({tag, "_busy_cmp"}, busy, 1);
        check({tag, "_hit_on_p2"}, hit_on_p2, e2);
        check({tag, "_hit_on_p1"}, hit_on_p1, e1);
        check({tag, "_trade"}, trade, e1 && e2);
        check({tag, "_p1_score"}, p1_score, m_sc1);
        check({tag, "_p2_score"}, p2_score, m_sc2);
        @(posedge clk); #1;
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_pulse_end"}, {hit_on_p1, hit_on_p2, trade}, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        all_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_tick("basic", 4, 100, 50, 1, 0, 180, 50, 0, 0);
        do_tick("idle", 0, 100, 50, 1, 0, 180, 50, 0, 0);
        do_tick("edge_miss", 4, 100, 50, 1, 0, 184, 50, 0, 0);
        do_tick("edge_hit", 4, 100, 50, 1, 0, 183, 50, 0, 0);
        do_tick("idle", 0, 0, 0, 0, 0, 500, 0, 0, 0);
        do_tick("left_clamp", 4, 20, 50, 0, 0, 0, 50, 0, 0);
        do_tick("idle", 0, 0, 0, 0, 0, 500, 0, 0, 0);
        do_tick("left_miss", 4, 20, 50, 0, 0, 10, 50, 0, 0);
        do_tick("recov_miss", 4, 100, 50, 1, 0, 190, 50, 0, 0);
        do_tick("recov_ext", 4, 100, 50, 1, 5, 190, 50, 0, 0);
        do_tick("right_clamp", 4, 1000, 50, 1, 0, 1000, 50, 0, 0);

        for (int i = 0; i < 5; i++) do_tick("hold", 4, 100, 50, 1, 0, 170, 50, 0, 0);
        do_tick("recover", 5, 100, 50, 1, 0, 170, 50, 0, 0);
        do_tick("rehit", 4, 100, 50, 1, 0, 170, 50, 0, 0);

        for (int i = 0; i < 17; i++) begin
            do_tick("trade", 4, 100, 50, 1, 4, 150, 50, 0, 0);
            do_tick("rest", 0, 100, 50, 1, 0, 150, 50, 0, 0);
        end

        // Reset asserted while the resolve sits in BOX
        p1_state = 3'd4; p1_x = 10'd100; p1_y = 10'd50; p1_face = 1'b1;
        p2_state = 3'd4; p2_x = 10'd150; p2_y = 10'd50; p2_face = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        all_outputs_zero("abort");
        m_sc1 = 0; m_sc2 = 0; m_done1 = 0; m_done2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_pulse", {hit_on_p1, hit_on_p2, trade, busy}, 0);
        end

        do_tick("pre_clear", 4, 100, 50, 1, 0, 170, 50, 0, 0);
        do_tick("idle", 0, 100, 50, 1, 0, 170, 50, 0, 0);
        do_tick("clear_report", 4, 100, 50, 1, 0, 170, 50, 0, 1);

        // A second tick while busy must not start another resolve
        p1_state = 3'd0; p2_state = 3'd0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        p1_state = 3'd4; p1_x = 10'd100; p1_y = 10'd50; p1_face = 1'b1;
        p2_state = 3'd0; p2_x = 10'd170; p2_y = 10'd50;
        @(posedge clk); #1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        m_done1 = 0; m_done2 = 0;
        check("busy_tick_hit2", hit_on_p2, 0);
        @(posedge clk); #1;
        check("busy_tick_idle", busy, 0);
        @(posedge clk); #1;
        check("busy_tick_ignored", busy, 0);

        round_clear = 1'b1;
        @(posedge clk); #1;
        round_clear = 1'b0;
        m_sc1 = 0; m_sc2 = 0; m_done1 = 0; m_done2 = 0;
        check("idle_clear_sc1", p1_score, 0);
        check("idle_clear_sc2", p2_score, 0);

        for (int i = 0; i < 120; i++) begin
            int s[2], x[2], y[2], f[2];
            for (int k = 0; k < 2; k++) begin
                s[k] = $urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : ($urandom_range(0, 2) == 0 ? 5 : 4);
                x[k] = $urandom_range(0, 7) == 0 ? $urandom_range(0, 1023) : $urandom_range(40, 260);
                y[k] = $urandom_range(0, 7) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 120);
                f[k] = $urandom_range(0, 1);
            end
            do_tick("rand", s[0], x[0], y[0], f[0], s[1], x[1], y[1], f[1], $urandom_range(0, 15) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
